// File: rtl/uproc_pkg.sv
// Shared datapath definitions for the uProcessor: ALU opcodes and default width.
package uproc_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned OP_W       = 4;

   typedef enum logic [OP_W-1:0] {
      NOP = 4'd0,
      LD,
      ADD,
      SUB,
      AND,
      OR,
      XOR,
      SHL,
      SHR,
      MUL
   } alu_op_t;

endpackage

// File: rtl/accu_alu_if.sv
// Control-unit <-> accumulator/ALU bus: op issue, operands, result and handshake.
interface accu_alu_if #(
   parameter int unsigned DATA_W = uproc_pkg::DEF_DATA_W
);

   logic                     op_valid;
   logic [uproc_pkg::OP_W-1:0] op;
   logic                     imm_sel;
   logic [DATA_W-1:0]        imm;
   logic [DATA_W-1:0]        reg_in;
   logic [DATA_W-1:0]        A;
   logic                     zero;
   logic                     carry;
   logic                     busy;
   logic                     done;

   modport master (
      output op_valid, op, imm_sel, imm, reg_in,
      input  A, zero, carry, busy, done
   );

   modport slave (
      input  op_valid, op, imm_sel, imm, reg_in,
      output A, zero, carry, busy, done
   );

endinterface

// File: rtl/mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle for DATA_W cycles.
module mul_seq
   import uproc_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  nReset,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   mplier;

   // product already folds in the current step, so the final sum is ready on the last busy edge
   always_comb begin
      product = acc + (mplier[0] ? mcand : '0);
      done    = busy && (cnt == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{DATA_W{1'b0}}, a};
         mplier <= b;
      end
   end

endmodule

// File: rtl/accu_alu.sv
// Accumulator A with Z/C flags, single-cycle ALU and sequenced multiply behind busy/done.
module accu_alu
   import uproc_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic        clk,
   input  logic        nReset,
   accu_alu_if.slave   bus
);

   logic [DATA_W-1:0]   opnd;
   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   alu_a;
   logic                alu_c;
   logic                alu_wr;
   logic                accept;
   logic                mul_start;
   logic                mul_busy;
   logic                mul_done;
   logic [2*DATA_W-1:0] product;

   logic [DATA_W-1:0]   a_q;
   logic                zero_q;
   logic                carry_q;
   logic                done_q;

   always_comb begin
      opnd   = bus.imm_sel ? bus.imm : bus.reg_in;
      sum    = {1'b0, a_q} + {1'b0, opnd};
      alu_a  = a_q;
      alu_c  = carry_q;
      alu_wr = 1'b0;
      case (alu_op_t'(bus.op))
         LD:  begin alu_a = opnd;                               alu_wr = 1'b1; end
         ADD: begin {alu_c, alu_a} = sum;                       alu_wr = 1'b1; end
         SUB: begin alu_a = a_q - opnd; alu_c = (a_q < opnd);   alu_wr = 1'b1; end
         AND: begin alu_a = a_q & opnd;                         alu_wr = 1'b1; end
         OR:  begin alu_a = a_q | opnd;                         alu_wr = 1'b1; end
         XOR: begin alu_a = a_q ^ opnd;                         alu_wr = 1'b1; end
         SHL: begin alu_c = a_q[DATA_W-1]; alu_a = a_q << 1;    alu_wr = 1'b1; end
         SHR: begin alu_c = a_q[0];        alu_a = a_q >> 1;    alu_wr = 1'b1; end
         default: ;
      endcase
   end

   // MUL is not an ALU write: the multiplier owns A until its done edge
   always_comb begin
      accept    = bus.op_valid && !mul_busy;
      mul_start = accept && (alu_op_t'(bus.op) == MUL);
   end

   mul_seq #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk),
      .nReset  (nReset),
      .start   (mul_start),
      .a       (a_q),
      .b       (opnd),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         a_q     <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (mul_done) begin
            a_q     <= product[DATA_W-1:0];
            carry_q <= |product[2*DATA_W-1:DATA_W];
            zero_q  <= (product[DATA_W-1:0] == '0);
            done_q  <= 1'b1;
         end else if (accept && alu_wr) begin
            a_q     <= alu_a;
            carry_q <= alu_c;
            zero_q  <= (alu_a == '0);
            done_q  <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.A     = a_q;
      bus.zero  = zero_q;
      bus.carry = carry_q;
      bus.busy  = mul_busy;
      bus.done  = done_q;
   end

endmodule

// File: tb/tb_accu_alu.sv
// Self-checking bench for accu_alu: directed scenarios plus random ops against an arithmetic model.
module tb_accu_alu;
   import uproc_pkg::*;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic clk = 1'b0;
   logic nReset = 1'b1;
   always #5 clk = ~clk;

   accu_alu_if #(.DATA_W(W)) bus();

   accu_alu #(.DATA_W(W)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus.slave)
   );

   int assertions = 0;
   int failures   = 0;

   // Architectural model: accumulator and flags as plain integers
   int m_a = 0;
   int m_c = 0;
   int m_z = 0;

   function automatic bit model_apply(input int o, input int opnd);
      int r;
      bit wr;
      wr = 1'b1;
      case (o)
         1: m_a = opnd;
         2: begin r = m_a + opnd; m_c = int'(r >= M); m_a = r % M; end
         3: begin m_c = int'(m_a < opnd); m_a = (m_a - opnd + M) % M; end
         4: m_a = m_a & opnd;
         5: m_a = m_a | opnd;
         6: m_a = m_a ^ opnd;
         7: begin m_c = m_a / (M / 2); m_a = (m_a * 2) % M; end
         8: begin m_c = m_a % 2; m_a = m_a / 2; end
         9: begin r = m_a * opnd; m_c = int'(r >= M); m_a = r % M; end
         default: wr = 1'b0;
      endcase
      if (wr) m_z = int'(m_a == 0);
      return wr;
   endfunction

   function automatic logic [W+3:0] status();
      return {bus.A, bus.zero, bus.carry, bus.done, bus.busy};
   endfunction

   function automatic logic [W+3:0] expv(input bit d, input bit b);
      return {W'(m_a), m_z[0], m_c[0], d, b};
   endfunction

   // Issue one op; returns just after the accept edge
   task automatic drive(input int o, input bit sel, input int im, input int rg);
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op       = 4'(o);
      bus.imm_sel  = sel;
      bus.imm      = W'(im);
      bus.reg_in   = W'(rg);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
   endtask

   task automatic test_reset();
      bit wr;
      drive(1, 1'b1, 77, 0);
      wr = model_apply(1, 77);
      @(negedge clk);
      #2 nReset = 1'b0;
      #1;
      m_a = 0; m_c = 0; m_z = 0;
      assertions++;
      if (status() !== '0) begin
         failures++;
         $display("FAIL reset_async: {A,Z,C,done,busy} got %h want %h", status(), {(W+4){1'b0}});
      end
      @(negedge clk);
      nReset = 1'b1;
   endtask

   task automatic test_ld_add();
      bit wr;
      drive(1, 1'b1, 200, 0);
      wr = model_apply(1, 200);
      assertions++;
      if (status() !== expv(wr, 1'b0)) begin
         failures++;
         $display("FAIL ld_200: got %h want %h", status(), expv(wr, 1'b0));
      end
      drive(2, 1'b1, 100, 0);
      wr = model_apply(2, 100);
      assertions++;
      if (status() !== expv(wr, 1'b0) || bus.A !== 8'd44 || bus.carry !== 1'b1) begin
         failures++;
         $display("FAIL add_100: got %h want %h (A=44 C=1)", status(), expv(wr, 1'b0));
      end
      @(posedge clk);
      #1;
      assertions++;
      if (status() !== expv(1'b0, 1'b0)) begin
         failures++;
         $display("FAIL done_one_cycle: got %h want %h", status(), expv(1'b0, 1'b0));
      end
   endtask

   task automatic test_sub();
      bit wr;
      drive(1, 1'b0, 0, 44);
      wr = model_apply(1, 44);
      drive(3, 1'b1, 44, 0);
      wr = model_apply(3, 44);
      assertions++;
      if (status() !== expv(wr, 1'b0) || bus.zero !== 1'b1) begin
         failures++;
         $display("FAIL sub_to_zero: got %h want %h", status(), expv(wr, 1'b0));
      end
      drive(3, 1'b1, 1, 0);
      wr = model_apply(3, 1);
      assertions++;
      if (status() !== expv(wr, 1'b0) || bus.A !== 8'd255 || bus.carry !== 1'b1) begin
         failures++;
         $display("FAIL sub_borrow: got %h want %h", status(), expv(wr, 1'b0));
      end
   endtask

   task automatic test_mul();
      int la, mb, n;
      bit wr;
      for (int k = 0; k < 2; k++) begin
         la = (k == 0) ? 13 : 20;
         mb = (k == 0) ? 11 : 20;
         drive(1, 1'b1, la, 0);
         wr = model_apply(1, la);
         drive(9, 1'b1, mb, 0);
         assertions++;
         if (status() !== expv(1'b0, 1'b1)) begin
            failures++;
            $display("FAIL mul_accept_%0d: got %h want %h", k, status(), expv(1'b0, 1'b1));
         end
         n = 0;
         while (bus.done !== 1'b1 && n < 3 * W) begin
            if (n == 3) begin
               bus.op_valid = 1'b1;
               bus.op       = 4'(2);
               bus.imm_sel  = 1'b1;
               bus.imm      = W'(5);
            end
            @(posedge clk);
            #1;
            n++;
            if (n == 4) bus.op_valid = 1'b0;
            if (bus.done !== 1'b1) begin
               assertions++;
               if (status() !== expv(1'b0, 1'b1)) begin
                  failures++;
                  $display("FAIL mul_hold_%0d_cyc%0d: got %h want %h", k, n, status(), expv(1'b0, 1'b1));
               end
            end
         end
         wr = model_apply(9, mb);
         assertions++;
         if (n != W) begin
            failures++;
            $display("FAIL mul_latency_%0d: got %0d edges want %0d", k, n, W);
         end
         assertions++;
         if (status() !== expv(1'b1, 1'b0)) begin
            failures++;
            $display("FAIL mul_result_%0d: got %h want %h", k, status(), expv(1'b1, 1'b0));
         end
      end
   endtask

   task automatic test_mul_reset();
      bit wr;
      bit bad;
      drive(1, 1'b1, 20, 0);
      wr = model_apply(1, 20);
      drive(9, 1'b1, 20, 0);
      repeat (3) @(posedge clk);
      #2 nReset = 1'b0;
      #1;
      m_a = 0; m_c = 0; m_z = 0;
      assertions++;
      if (status() !== '0) begin
         failures++;
         $display("FAIL mul_abort_reset: got %h want %h", status(), {(W+4){1'b0}});
      end
      @(negedge clk);
      nReset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clk);
         #1;
         if (status() !== expv(1'b0, 1'b0)) bad = 1'b1;
      end
      assertions++;
      if (bad) begin
         failures++;
         $display("FAIL mul_abort_no_done: got %h want %h", status(), expv(1'b0, 1'b0));
      end
   endtask

   task automatic test_shift();
      bit wr;
      int ops [4] = '{1, 7, 8, 4};
      int vals[4] = '{'h81, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], 1'b1, vals[i], 0);
         wr = model_apply(ops[i], vals[i]);
         assertions++;
         if (status() !== expv(wr, 1'b0)) begin
            failures++;
            $display("FAIL shift_step%0d: got %h want %h", i, status(), expv(wr, 1'b0));
         end
      end
   endtask

   task automatic test_random();
      int o, im, rg, opnd, n;
      bit sel, wr;
      for (int i = 0; i < 300; i++) begin
         o    = int'($urandom_range(0, 15));
         sel  = 1'($urandom_range(0, 1));
         im   = int'($urandom_range(0, M - 1));
         rg   = int'($urandom_range(0, M - 1));
         opnd = sel ? im : rg;
         drive(o, sel, im, rg);
         if (o == 9) begin
            assertions++;
            if (status() !== expv(1'b0, 1'b1)) begin
               failures++;
               $display("FAIL rnd_mul_accept_%0d: got %h want %h", i, status(), expv(1'b0, 1'b1));
            end
            n = 0;
            while (bus.done !== 1'b1 && n < 3 * W) begin
               @(posedge clk);
               #1;
               n++;
            end
            wr = model_apply(o, opnd);
            assertions++;
            if (n != W || status() !== expv(1'b1, 1'b0)) begin
               failures++;
               $display("FAIL rnd_mul_%0d: got %h after %0d edges want %h after %0d", i, status(), n, expv(1'b1, 1'b0), W);
            end
         end else begin
            wr = model_apply(o, opnd);
            assertions++;
            if (status() !== expv(wr, 1'b0)) begin
               failures++;
               $display("FAIL rnd_op%0d_%0d: got %h want %h", o, i, status(), expv(wr, 1'b0));
            end
         end
      end
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op       = '0;
      bus.imm_sel  = 1'b0;
      bus.imm      = '0;
      bus.reg_in   = '0;
      #1 nReset = 1'b0;
      #19 nReset = 1'b1;
      test_reset();
      test_ld_add();
      test_sub();
      test_mul();
      test_mul_reset();
      test_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
